shift_add_multiplier: RTL and testbench

- Sequential unsigned multiplier using the pen-and-paper shift-and-add algorithm. It is the inverse companion of the team's 32-bit long-division divider.
- Uses the same start/done operand interface as the divider, so the two blocks can be chained: multiply quotient by divisor, add remainder, and compare against the dividend for self-checking.
- Internally split into a controller FSM and a datapath (accumulator, multiplier/low-product shift register, iteration counter).

---
 rtl/shift_add_multiplier.sv | 124 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier (size x size -> 2*size), start/done handshake.
// Optional early termination when no multiplier bits remain: define MULT_EARLY_TERM_EN.
module shift_add_multiplier #(
    parameter int unsigned size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [size-1:0] multiplicand,
    input  logic [size-1:0] multiplier,
    output logic [size-1:0] product_hi,
    output logic [size-1:0] product_lo,
    output logic            busy,
    output logic            done
);

    localparam int unsigned CNT_W  = $clog2(size + 1);
    localparam int unsigned ACC_W  = size + 1;
    localparam int unsigned PROD_W = 2 * size;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [size-1:0]   m_q;
    logic [size-1:0]   q_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_nxt;
    logic [size-1:0]   q_nxt;
    logic [size-1:0]   res_hi;
    logic [size-1:0]   res_lo;
    logic              last;

`ifdef MULT_EARLY_TERM_EN
    logic [size-1:0]   rem_mask;
    logic [PROD_W-1:0] wide;
`endif

    // One shift-and-add iteration, plus the finishing decision for this edge
    always_comb begin
        sum     = q_q[0] ? (acc_q + ACC_W'(m_q)) : acc_q;
        acc_nxt = {1'b0, sum[ACC_W-1:1]};
        q_nxt   = {sum[0], q_q[size-1:1]};
        res_hi  = acc_nxt[size-1:0];
        res_lo  = q_nxt;
        last    = (cnt_q == CNT_W'(1));
`ifdef MULT_EARLY_TERM_EN
        // Unconsumed multiplier bits live in q_q[cnt-1:0]; bits above 0 all clear means done
        rem_mask = (size'(1) << (cnt_q - CNT_W'(1))) - size'(1);
        wide     = PROD_W'({sum, q_q} >> cnt_q);
        if (((q_q >> 1) & rem_mask) == '0) begin
            last   = 1'b1;
            res_hi = wide[PROD_W-1:size];
            res_lo = wide[size-1:0];
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q        <= '0;
            q_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_hi <= '0;
            product_lo <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q   <= multiplicand;
                        acc_q <= '0;
                        q_q   <= multiplier;
                        cnt_q <= CNT_W'(size);
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last) begin
                        product_hi <= res_hi;
                        product_lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus random operands
// checked against plain 64-bit multiplication and the iteration-count rule.
module tb_shift_add_multiplier;

    localparam int unsigned SIZE = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [SIZE-1:0] multiplicand;
    logic [SIZE-1:0] multiplier;
    logic [SIZE-1:0] product_hi;
    logic [SIZE-1:0] product_lo;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    shift_add_multiplier #(.size(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product_hi   (product_hi),
        .product_lo   (product_lo),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Iterations from the multiplier value alone
    function automatic int exp_iters(input logic [SIZE-1:0] b);
        int m;
        m = 0;
`ifdef MULT_EARLY_TERM_EN
        for (int i = 0; i < int'(SIZE); i++) if (b[i]) m = i + 1;
        if (m == 0) m = 1;
`else
        m = int'(SIZE) + 0 * int'(b[0]);
`endif
        return m;
    endfunction

    // Present operands with start for one edge (edge 0), then scramble the operand inputs
    task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Count edges until done is seen (bounded), and busy-high samples including the current one
    task automatic wait_done(output int n, output int busy_cnt);
        n        = 0;
        busy_cnt = busy ? 1 : 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
            if (done) break;
        end
    endtask

    task automatic run_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int n;
        int bc;
        logic [63:0] exp;
        exp = 64'(a) * 64'(b);
        issue(a, b);
        check({tag, ":start"}, 64'({busy, done}), 64'(2'b10));
        wait_done(n, bc);
        check({tag, ":latency"}, 64'(n), 64'(exp_iters(b)));
        check({tag, ":busy_cycles"}, 64'(bc), 64'(exp_iters(b) + 1));
        check({tag, ":product"}, {product_hi, product_lo}, exp);
        @(posedge clk);
        #1;
        check({tag, ":idle"}, 64'({busy, done}), 64'(2'b00));
        check({tag, ":hold"}, {product_hi, product_lo}, exp);
    endtask

    initial begin
        int n;
        int bc;
        int done_seen;
        logic [SIZE-1:0] ra;
        logic [SIZE-1:0] rb;

        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #12;
        check("reset_state", {product_hi, product_lo}, 64'd0);
        check("reset_flags", 64'({busy, done}), 64'(2'b00));
        @(negedge clk);
        reset = 1'b1;

        run_op("small_7x6", 32'd7, 32'd6);
        check("small_7x6:lo_const", 64'(product_lo), 64'd42);

        run_op("max_x_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_x_max:const", {product_hi, product_lo}, 64'hFFFF_FFFE_0000_0001);

        run_op("b_zero", 32'h1234_5678, 32'd0);
        run_op("a_zero", 32'd0, 32'h9ABC_DEF0);
        run_op("early_5x3", 32'd5, 32'd3);

`ifndef MULT_EARLY_TERM_EN
        // Second start at edge 10 while busy must be ignored
        issue(32'd3, 32'd5);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bc);
        check("busy_start:latency", 64'(n), 64'(exp_iters(32'd5) - 10));
        check("busy_start:product", {product_hi, product_lo}, 64'd15);
        @(posedge clk);
        #1;
`endif
        run_op("after_busy_9x9", 32'd9, 32'd9);

        // Reset mid-operation aborts with no done pulse
        issue(32'hDEAD_BEEF, 32'h10);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_reset:product", {product_hi, product_lo}, 64'd0);
        check("mid_reset:flags", 64'({busy, done}), 64'(2'b00));
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("mid_reset:no_done", 64'(done_seen), 64'd0);
        run_op("after_reset_2x3", 32'd2, 32'd3);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
